// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel double-buffered PWM with CSR access (optional PWM_POLARITY_EN)
module pwm_multi #(
    parameter logic [4:0] BASE_ADDR = 5'h0,
    parameter int         CHANNELS  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_ce,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    output logic                pwm_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                irq
);

    logic [4:0] off_full;
    logic       hit;
    logic [2:0] off;

    logic                     ctrl_en;
    logic [CHANNELS-1:0]      ch_en;
    logic [7:0]               period_reg;
    logic [7:0]               period_sh;
    logic [CHANNELS-1:0][7:0] duty_reg;
    logic [CHANNELS-1:0][7:0] duty_sh;
    logic [7:0]               counter;
    logic                     flag;
    logic                     irq_en;
    logic [CHANNELS-1:0]      pol;
    logic [CHANNELS-1:0]      raw;
    logic                     wrap;
    logic                     wr_ctrl, wr_period, wr_status;
    logic                     unused_di;

    // The window is found by subtraction so BASE_ADDR need not be 8-aligned.
    assign off_full  = csr_a - BASE_ADDR;
    assign hit       = (off_full[4:3] == 2'b00);
    assign off       = off_full[2:0];
    assign wr_ctrl   = csr_we & hit & (off == 3'd0);
    assign wr_period = csr_we & hit & (off == 3'd1);
    assign wr_status = csr_we & hit & (off == 3'd2);
    assign wrap      = ctrl_en & pwm_ce & (counter == period_sh);
    assign unused_di = &{1'b0, csr_di};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en    <= 1'b0;
            ch_en      <= '0;
            period_reg <= 8'hFF;
            duty_reg   <= '0;
            irq_en     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en <= csr_di[7];
                ch_en   <= csr_di[CHANNELS-1:0];
            end
            if (wr_period) period_reg <= csr_di;
            if (wr_status) irq_en <= csr_di[7];
            for (int n = 0; n < CHANNELS; n++) begin
                if (csr_we && hit && (off == 3'(3 + n))) duty_reg[n] <= csr_di;
            end
        end
    end

    // Shadows track the registers while stopped and reload only at a wrap while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            period_sh <= 8'hFF;
            duty_sh   <= '0;
        end else if (!ctrl_en) begin
            counter   <= '0;
            period_sh <= period_reg;
            duty_sh   <= duty_reg;
        end else if (pwm_ce) begin
            if (counter == period_sh) begin
                counter   <= '0;
                period_sh <= period_reg;
                duty_sh   <= duty_reg;
            end else begin
                counter <= counter + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= 1'b0;
        end else if (wrap) begin
            flag <= 1'b1;
        end else if (wr_status && csr_di[0]) begin
            flag <= 1'b0;
        end
    end

`ifdef PWM_POLARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol <= '0;
        end else if (csr_we && hit && (off == 3'd7)) begin
            pol <= csr_di[CHANNELS-1:0];
        end
    end
`else
    assign pol = '0;
`endif

    always_comb begin
        raw = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            raw[n] = ctrl_en & ch_en[n] & (counter < duty_sh[n]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= raw ^ pol;
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (hit) begin
            case (off)
                3'd0: csr_do = {ctrl_en, 3'b000, 4'(ch_en)};
                3'd1: csr_do = period_reg;
                3'd2: csr_do = {irq_en, 6'b000000, flag};
`ifdef PWM_POLARITY_EN
                3'd7: csr_do = {4'b0000, 4'(pol)};
`endif
                default: begin
                    for (int n = 0; n < CHANNELS; n++) begin
                        if (off == 3'(3 + n)) csr_do = duty_reg[n];
                    end
                end
            endcase
        end
    end

    assign pwm_en = ctrl_en;
    assign irq    = flag & irq_en;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - randomized and directed bench for pwm_multi against a period/phase model
module tb_pwm_multi;
    localparam int         CH   = 3;
    localparam logic [4:0] BASE = 5'h08;
    localparam logic [3:0] MASK = 4'((1 << CH) - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pwm_ce = 1'b0;
    logic [4:0]    csr_a = '0;
    logic [7:0]    csr_di = '0;
    logic          csr_we = 1'b0;
    logic [7:0]    csr_do;
    logic          pwm_en;
    logic [CH-1:0] pwm_out;
    logic          irq;

    int total = 0;
    int bad = 0;

    pwm_multi #(.BASE_ADDR(BASE), .CHANNELS(CH)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_ce(pwm_ce), .csr_a(csr_a), .csr_di(csr_di),
        .csr_we(csr_we), .csr_do(csr_do), .pwm_en(pwm_en), .pwm_out(pwm_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: a period of m_len ticks, current phase m_pos, duty values latched at period start.
    bit       m_en, m_irqen, m_flag;
    bit [3:0] m_chen, m_pol;
    int       m_period;
    int       m_duty[4];
    int       m_dl[4];
    int       m_pos, m_len;
    bit [CH-1:0] m_out;

    task automatic m_reset();
        m_en = 0; m_irqen = 0; m_flag = 0; m_chen = 0; m_pol = 0;
        m_period = 255; m_pos = 0; m_len = 256; m_out = '0;
        for (int n = 0; n < 4; n++) begin m_duty[n] = 0; m_dl[n] = 0; end
    endtask

    task automatic m_step(input bit ce, input bit we, input logic [4:0] a, input logic [7:0] di);
        logic [4:0] d;
        bit wrap;
        bit [CH-1:0] nout;
        d = a - BASE;
        wrap = 0;
        for (int n = 0; n < CH; n++)
            nout[n] = (m_en && m_chen[n] && (m_pos < m_dl[n])) ^ m_pol[n];
        if (!m_en) begin
            m_pos = 0; m_len = m_period + 1; m_dl = m_duty;
        end else if (ce) begin
            m_pos = m_pos + 1;
            if (m_pos == m_len) begin
                m_pos = 0; m_len = m_period + 1; m_dl = m_duty; wrap = 1;
            end
        end
        if (wrap) m_flag = 1;
        else if (we && d == 5'd2 && di[0]) m_flag = 0;
        if (we && d < 5'd8) begin
            case (d)
                5'd0: begin m_en = di[7]; m_chen = di[3:0] & MASK; end
                5'd1: m_period = int'(di);
                5'd2: m_irqen = di[7];
`ifdef PWM_POLARITY_EN
                5'd7: m_pol = di[3:0] & MASK;
`endif
                default: if (d >= 5'd3 && d <= 5'd6 && int'(d) - 3 < CH) m_duty[int'(d) - 3] = int'(di);
            endcase
        end
        m_out = nout;
    endtask

    function automatic logic [7:0] mread(input logic [4:0] a);
        logic [4:0] d;
        d = a - BASE;
        if (d >= 5'd8) return 8'h00;
        case (d)
            5'd0: return {m_en, 3'b000, m_chen};
            5'd1: return 8'(m_period);
            5'd2: return {m_irqen, 6'b000000, m_flag};
`ifdef PWM_POLARITY_EN
            5'd7: return {4'b0000, m_pol};
`endif
            5'd3, 5'd4, 5'd5, 5'd6: return (int'(d) - 3 < CH) ? 8'(m_duty[int'(d) - 3]) : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; applies one clock of stimulus and checks the outputs.
    task automatic tick(input bit ce, input bit we, input logic [4:0] a, input logic [7:0] di);
        pwm_ce = ce; csr_we = we; csr_a = a; csr_di = di;
        @(posedge clk);
        m_step(ce, we, a, di);
        @(negedge clk);
        pwm_ce = 1'b0; csr_we = 1'b0;
        chk("pwm_out", 32'(pwm_out), 32'(m_out));
        chk("irq", 32'(irq), 32'(m_flag & m_irqen));
        chk("pwm_en", 32'(pwm_en), 32'(m_en));
    endtask

    task automatic wr(input int o, input logic [7:0] di);
        tick(1'b1, 1'b1, BASE + 5'(o), di);
    endtask

    task automatic rd(input logic [4:0] a, input string tag);
        csr_we = 1'b0; csr_a = a;
        #1;
        chk(tag, 32'(csr_do), 32'(mread(a)));
    endtask

    task automatic wait_prewrap();
        int k;
        k = 0;
        while (!(m_en && m_pos == m_len - 1) && k < 600) begin
            tick(1'b1, 1'b0, 5'd0, 8'h00);
            k++;
        end
        chk("wrap_wait", 32'(k < 600), 32'd1);
    endtask

    initial begin
        m_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out", 32'(pwm_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int o = 0; o < 8; o++) rd(BASE + 5'(o), "reset_read");
        rd(5'h02, "out_of_window");
        rd(BASE + 5'd8, "past_window");

        // 4-clk period, duty 2 on channel 0
        wr(1, 8'd3);
        wr(3, 8'd2);
        wr(0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 5'd0, 8'h00);
            chk("pattern_1100", 32'(pwm_out[0]), 32'((i % 4) < 2));
            chk("ch1_idle", 32'(pwm_out[1]), 32'd0);
        end

        // duty change just after a wrap applies at the next period only
        wr(3, 8'd1);
        wait_prewrap();
        tick(1'b1, 1'b0, 5'd0, 8'h00);
        wr(3, 8'd3);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 5'd0, 8'h00);

        wr(3, 8'd0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 5'd0, 8'h00);
        chk("duty0_zero", 32'(pwm_out[0]), 32'd0);
        wr(3, 8'd4);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 5'd0, 8'h00);
        chk("duty_full", 32'(pwm_out[0]), 32'd1);
        wr(3, 8'd2);
        wr(0, 8'h87);
        wr(4, 8'd1);
        for (int i = 0; i < 40; i++) tick(i % 4 == 0, 1'b0, 5'd0, 8'h00);

        // wrap flag and interrupt
        wr(2, 8'h80);
        wait_prewrap();
        tick(1'b1, 1'b0, 5'd0, 8'h00);
        chk("irq_on_wrap", 32'(irq), 32'd1);
        wait_prewrap();
        tick(1'b1, 1'b1, BASE + 5'd2, 8'h81);
        chk("w1c_vs_set", 32'(irq), 32'd1);
        tick(1'b0, 1'b1, BASE + 5'd2, 8'h80);
        chk("w0_no_clear", 32'(irq), 32'd1);
        tick(1'b0, 1'b1, BASE + 5'd2, 8'h81);
        chk("w1c_clear", 32'(irq), 32'd0);
        rd(BASE + 5'd2, "status_read");

`ifdef PWM_POLARITY_EN
        wr(7, 8'h01);
        wr(0, 8'h80);
        tick(1'b1, 1'b0, 5'd0, 8'h00);
        chk("pol_idle_high", 32'(pwm_out[0]), 32'd1);
        wr(0, 8'h00);
        wr(1, 8'd3);
        wr(3, 8'd2);
        wr(0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 5'd0, 8'h00);
            chk("pol_pattern", 32'(pwm_out[0]), 32'((i % 4) >= 2));
        end
        wr(7, 8'h00);
`endif

        // randomized register traffic and tick patterns
        for (int i = 0; i < 500; i++) begin
            int o;
            logic [7:0] di;
            logic [4:0] a;
            o = int'($urandom_range(0, 7));
            di = 8'($urandom_range(0, 255));
            if (o == 0) di[7] = ($urandom_range(0, 3) != 0);
            if (o == 1 || (o >= 3 && o <= 6)) di = 8'($urandom_range(0, 12));
            a = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : BASE + 5'(o);
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, a, di);
            if (i % 8 == 0) rd(5'($urandom_range(0, 31)), "rand_read");
        end

        // asynchronous reset in the middle of a running period
        wr(1, 8'd5);
        wr(3, 8'd6);
        wr(0, 8'h81);
        wr(2, 8'h80);
        wait_prewrap();
        tick(1'b1, 1'b0, 5'd0, 8'h00);
        tick(1'b1, 1'b0, 5'd0, 8'h00);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        chk("pre_rst_out", 32'(pwm_out[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(pwm_out), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int o = 0; o < 8; o++) rd(BASE + 5'(o), "post_rst_read");
        csr_a = BASE + 5'd1;
        #1;
        chk("post_rst_period", 32'(csr_do), 32'hFF);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 5'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel, glitch-free PWM generator; successor to the single-channel PWM block. Channels share one period counter, advanced by the external prescaler tick pwm_ce, with a programmable (non-power-of-two) period. Duty and period values are double-buffered. A period-wrap status flag can drive an interrupt. It sits on the 8-bit CSR bus next to the other CPLD peripherals.

Parameters:
BASE_ADDR, 5'h0, CSR base address; the block decodes BASE_ADDR..BASE_ADDR+7.
CHANNELS, 2, number of PWM outputs; legal range 1..4.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
pwm_ce  in  1  counter tick enable, 1 clk wide
csr_a  in  5  CSR address
csr_di  in  8  CSR write data
csr_we  in  1  CSR write strobe
csr_do  out  8  CSR read data, combinational
pwm_en  out  1  global enable, registered copy of CTRL[7]
pwm_out  out  CHANNELS  PWM outputs, registered
irq  out  1  interrupt, level, active-high

Behaviour:
- Reset is asynchronous and active-low. When rst_n=0:
  - CTRL=0, PERIOD=8'hFF, DUTYn=0, STATUS=0, counter=0.
  - Shadow registers: period 8'hFF, duties 0.
  - pwm_en=0, pwm_out=0, irq=0.
- Register map (offsets from BASE_ADDR):
  - +0 CTRL: [7] en; [3:0] ch_en; bits for channels >= CHANNELS and [6:4] are read 0, write ignored.
  - +1 PERIOD: the period is PERIOD+1 ticks.
  - +2 STATUS: [0] wrap flag, write-1-to-clear; [7] irq_en, read/write; other bits read 0.
  - +3..+6 DUTYn: n = 0..3. Unimplemented channels read 0 and ignore writes.
  - +7: see Optional Feature.
  - Any other address reads 0.
- Writes take effect on the clk edge at which csr_we=1.
- Counter behaviour:
  - en=0: the counter is held at 0, and the shadow registers copy PERIOD/DUTYn every clk.
  - en=1 and pwm_ce=1, counter != period_shadow: counter increments by 1.
  - en=1 and pwm_ce=1, counter == period_shadow: counter goes to 0, the shadows load PERIOD/DUTYn, and the wrap flag sets.
  - pwm_ce=0: the counter holds.
- Output rule: each clk, pwm_out[n] <= en & ch_en[n] & (counter < duty_shadow[n]). Output latency is 1 clk after the counter.
  - duty=0: constant 0.
  - duty > PERIOD: constant 1 (100%).
- Glitch-free update: changes to PERIOD/DUTY written while en=1 are applied only at the next wrap. Each period is therefore always emitted whole.
- ch_en and en changes are not deferred. They gate the outputs at the next clk edge. Clearing en restarts the counter at 0. On re-enable, the first period uses the current register values.
- PERIOD is written below the current counter value while running: no effect until the wrap. The counter continues to the old period_shadow.
- Wrap flag:
  - If a set and a W1C occur in the same clk, set wins.
  - Software writes to STATUS[0] with value 0 have no effect.
- irq = flag & irq_en, registered-free (combinational from flops).
- pwm_en output = CTRL[7].
- Reset asserted mid-period: outputs go to 0 immediately (asynchronous). After release, the block is idle (en=0).

Optional Feature:
Macro PWM_POLARITY_EN.
- Defined: offset +7 is POL, with [3:0] giving per-channel polarity (reset 0). pwm_out[n] is the rule above XOR pol[n]. Disabled or reset-gated channels therefore idle at pol[n]; after reset (pol=0) they idle at 0.
- Polarity changes take effect at the next clk, not deferred.
- Undefined: +7 reads 0, writes are ignored, and outputs are active-high.

Test Plan:
- PERIOD=3, DUTY0=2, CTRL=8'h81, pwm_ce=1 every clk -> pwm_out[0] repeats 1,1,0,0 (4-clk period); pwm_out[1]=0.
- Running with PERIOD=3, DUTY0=1; write DUTY0=3 one clk after a wrap -> remainder of current period keeps 1-high; next period is 1,1,1,0; no partial pulses.
- DUTY0=0 -> pwm_out[0] constant 0. DUTY0=4 with PERIOD=3 -> constant 1. pwm_ce asserted 1 clk in 4 -> period stretches to 16 clk, same duty ratio.
- STATUS irq_en=1 -> irq rises on first wrap. W1C on STATUS[0] in the same clk as a wrap -> flag stays 1. W1C in a non-wrap clk -> flag and irq drop next clk.
- Assert rst_n=0 mid-period, asynchronously off the clk edge -> pwm_out=0 and irq=0 without a clk edge. After release, all registers read reset values (PERIOD reads 8'hFF).
- PWM_POLARITY_EN defined, POL=8'h01, CTRL ch_en0=0 -> pwm_out[0]=1 (idle high). Enabled with DUTY0=2, PERIOD=3 -> pattern 0,0,1,1.
